nfault_monitor: RTL and testbench
=================================

NFAULT_MONITOR -- requirements
Module: nfault_monitor

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clk cycles after end of register access before nFault is sampled; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the nFault input synchroniser; legal range 2..3.
REQ-003 clk  input  1  single system clock; all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 register_address_valid  input  1  high while a bus register access is in progress; synchronous to clk.
REQ-006 nFault_in  input  1  shared open-drain fault line, asynchronous, low = fault; z/pulled-up reads as 1.
REQ-007 clear_fault  input  1  single-cycle pulse that clears latched fault status and count.
REQ-008 sample_done  output  1  one-cycle pulse when a post-access nFault sample has been evaluated.
REQ-009 fault_detected  output  1  sticky flag, set when any sample shows nFault low.
REQ-010 fault_irq  output  1  one-cycle pulse coincident with sample_done when that sample shows a fault.
REQ-011 fault_count  output  8  number of faulty samples since reset/clear, saturating.

Function
REQ-012 nFault_in SHALL pass through SYNC_STAGES flops before any use; the synchronised value is nf_s.
REQ-013 FSM states: S_M0 idle, S_M1 access active, S_M2 settle countdown, S_M3 sample, S_M4 report.
REQ-014 S_M0 -> S_M1 when register_address_valid = 1; otherwise stay in S_M0.
REQ-015 S_M1 -> S_M2 when register_address_valid = 0, loading the settle counter with SETTLE_CYCLES-1; otherwise stay in S_M1.
REQ-016 S_M2: decrement the counter each cycle; -> S_M3 when the counter = 0.
REQ-017 S_M2 with register_address_valid = 1 (new access) SHALL abort to S_M1 without sampling.
REQ-018 S_M3 SHALL capture nf_s into an internal fault_sample bit (fault = nf_s == 0) and go unconditionally to S_M4.
REQ-019 S_M4 SHALL assert sample_done for exactly one cycle, plus fault_irq if fault_sample = 1, then -> S_M0.
REQ-020 In S_M4 with fault_sample = 1, fault_detected SHALL be set on the next edge and fault_count incremented, saturating at 255.
REQ-021 Latency: the falling edge of register_address_valid to sample_done is SETTLE_CYCLES+2 clk cycles.
REQ-022 clear_fault SHALL zero fault_detected and fault_count on the next edge in any state; the FSM is unaffected.
REQ-023 If clear_fault and an S_M4 fault coincide, the result is fault_detected = 1 and fault_count = 1.
REQ-024 Unreachable state encodings SHALL return to S_M0 on the next edge.
REQ-025 nFault_in activity outside S_M3 SHALL NOT affect any output.

Reset
REQ-026 While reset = 1: state = S_M0; counter, synchroniser, fault_sample and filter all 0/1 inactive (synchroniser flops = 1).
REQ-027 Reset outputs: sample_done = 0, fault_irq = 0, fault_detected = 0, fault_count = 0.
REQ-028 Reset asserted mid-access or mid-settle SHALL abandon the sample; no sample_done is produced after release until a new access completes.

Configuration
REQ-029 NFAULT_GLITCH_FILTER_EN defined: nf_s SHALL be replaced by a filtered value that changes only when 3 consecutive synchronised samples agree, which adds 2 cycles to input latency; FSM timing is unchanged.
REQ-030 NFAULT_GLITCH_FILTER_EN undefined: nf_s is used directly with no filter logic.

Verification
REQ-031 Access of 3 cycles, nFault_in = 1 throughout, SETTLE_CYCLES = 4 -> sample_done pulses 6 cycles after the fall of register_address_valid; fault_irq = 0; fault_count = 0.
REQ-032 Same access with nFault_in = 0 from the access start -> fault_irq and sample_done pulse together; fault_detected = 1; fault_count = 1.
REQ-033 register_address_valid re-asserted 2 cycles into settle -> no sample_done for the first access; exactly one sample_done after the second access ends.
REQ-034 256 faulty accesses -> fault_count = 255 (saturates); then clear_fault coinciding with a fault report -> fault_count = 1, fault_detected = 1.
REQ-035 Reset pulsed during S_M2 -> all outputs 0 and no sample_done until the next access completes.
REQ-036 With NFAULT_GLITCH_FILTER_EN: a 1-cycle low glitch on nFault_in around the sample point -> no fault; a low lasting 3+ cycles before the sample -> fault reported.

Source files
------------

// File: rtl/nfault_monitor_if.sv
// nfault_monitor_if: bus-side signal bundle of the nFault post-access monitor.
//
// register_address_valid is a level-valid with no ready: the master holds it
// high for every cycle a register access is in progress and drops it when the
// access ends. There is no back-pressure. The monitor reacts to the high-to-low
// transition. clear_fault is a single-cycle request that is always accepted.
// sample_done and fault_irq are single-cycle strobes that the consumer must
// take in the cycle they are high.
interface nfault_monitor_if;
    logic       register_address_valid;
    logic       nFault_in;
    logic       clear_fault;
    logic       sample_done;
    logic       fault_detected;
    logic       fault_irq;
    logic [7:0] fault_count;

    modport master (
        output register_address_valid,
        output nFault_in,
        output clear_fault,
        input  sample_done,
        input  fault_detected,
        input  fault_irq,
        input  fault_count
    );

    modport slave (
        input  register_address_valid,
        input  nFault_in,
        input  clear_fault,
        output sample_done,
        output fault_detected,
        output fault_irq,
        output fault_count
    );
endinterface

// File: rtl/nfault_monitor.sv
// nfault_monitor: samples the shared open-drain nFault line a fixed number of
// cycles after each register access ends, and keeps a sticky fault flag and a
// saturating count of faulty samples.
// Optional build macro NFAULT_GLITCH_FILTER_EN adds a 3-sample agreement
// filter after the synchroniser. It adds 2 cycles of input latency and leaves
// the FSM timing unchanged.
module nfault_monitor #(
    parameter int SETTLE_CYCLES = 4,  // 1..255
    parameter int SYNC_STAGES   = 2   // 2..3
) (
    input  logic            clk,
    input  logic            reset,
    nfault_monitor_if.slave bus,
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_M0 = 3'd0,  // idle
        S_M1 = 3'd1,  // access active
        S_M2 = 3'd2,  // settle countdown
        S_M3 = 3'd3,  // sample
        S_M4 = 3'd4   // report
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   fault_sample_q, fault_sample_d;
    logic                   fault_det_q, fault_det_d;
    logic [7:0]             fault_cnt_q, fault_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   nf_s;
    logic                   sample_done;

    // Synchroniser for the asynchronous nFault line. It resets to the idle (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.nFault_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef NFAULT_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       agree;

    // The filtered level follows the line only when the last 3 samples agree.
    assign agree = (sync_out == hist_q[0]) && (sync_out == hist_q[1]);
    assign nf_s  = agree ? sync_out : filt_q;

    // Sample history and held filter output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_out};
            filt_q <= nf_s;
        end
    end
`else
    assign nf_s = sync_out;
`endif

    // FSM and datapath state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_M0;
            cnt_q          <= 8'd0;
            fault_sample_q <= 1'b0;
            fault_det_q    <= 1'b0;
            fault_cnt_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fault_sample_q <= fault_sample_d;
            fault_det_q    <= fault_det_d;
            fault_cnt_q    <= fault_cnt_d;
        end
    end

    // Next state, settle counter, sample capture and report strobe.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fault_sample_d = fault_sample_q;
        sample_done    = 1'b0;
        case (state_q)
            S_M0: begin
                if (bus.register_address_valid) state_d = S_M1;
            end
            S_M1: begin
                if (!bus.register_address_valid) begin
                    state_d = S_M2;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_M2: begin
                // A new access during settle discards this sample entirely.
                if (bus.register_address_valid) begin
                    state_d = S_M1;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_M3;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_M3: begin
                fault_sample_d = ~nf_s;
                state_d        = S_M4;
            end
            S_M4: begin
                sample_done = 1'b1;
                state_d     = S_M0;
            end
            default: state_d = S_M0;
        endcase
    end

    // Sticky flag and saturating count. A clear that coincides with a fault
    // report restarts the count at 1.
    always_comb begin
        fault_det_d = fault_det_q;
        fault_cnt_d = fault_cnt_q;
        if (bus.clear_fault) begin
            fault_det_d = 1'b0;
            fault_cnt_d = 8'd0;
        end
        if (state_q == S_M4 && fault_sample_q) begin
            fault_det_d = 1'b1;
            if (fault_cnt_d != 8'hFF) fault_cnt_d = fault_cnt_d + 8'd1;
        end
    end

    assign bus.sample_done    = sample_done;
    assign bus.fault_irq      = sample_done & fault_sample_q;
    assign bus.fault_detected = fault_det_q;
    assign bus.fault_count    = fault_cnt_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_nfault_monitor.sv
// tb_nfault_monitor: scenario tasks for the nFault post-access monitor. The
// expected fault result of every completed access is queued when the access
// is driven. A negedge monitor pops the queue on each sample_done.
module tb_nfault_monitor;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    nfault_monitor_if bus ();

    nfault_monitor #(
        .SETTLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    logic [0:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_seen = 0;
    int         model_count = 0;
    logic       model_det = 1'b0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every sample_done must match a queued expectation.
    always @(negedge clk) begin
        logic [0:0] e;
        if (!reset) begin
            if (bus.sample_done) begin
                done_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample_done: got sample_done=1, required no pending sample");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.fault_irq !== e[0]) begin
                        n_fail++;
                        $display("FAIL irq_at_done: got fault_irq=%b, required %b", bus.fault_irq, e[0]);
                    end
                end
            end else if (bus.fault_irq !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL irq_without_done: got fault_irq=%b, required 0", bus.fault_irq);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_access(input int len, input logic nf);
        bus.nFault_in              = nf;
        bus.register_address_valid = 1'b1;
        repeat (len) step();
        bus.register_address_valid = 1'b0;
    endtask

    // Call right after register_address_valid drops. Returns at the negedge
    // where sample_done is seen. lat = cycles from the fall, or -1 on timeout.
    task automatic wait_sample(output int lat);
        lat = -1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.sample_done) begin
                lat = c;
                break;
            end
            if (c != 30) @(posedge clk);
        end
    endtask

    task automatic run_access(input int len, input logic nf, output int lat);
        exp_q.push_back(~nf);
        drive_access(len, nf);
        wait_sample(lat);
        if (!nf) begin
            model_det = 1'b1;
            if (model_count < 255) model_count++;
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        bus.register_address_valid = 1'b0;
        bus.nFault_in   = 1'b1;
        bus.clear_fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.sample_done, bus.fault_irq, bus.fault_detected} !== 3'b000 || bus.fault_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b irq=%b det=%b cnt=%0d, required all 0",
                     bus.sample_done, bus.fault_irq, bus.fault_detected, bus.fault_count);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        int lat;
        run_access(3, 1'b1, lat);
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL nominal_latency: got %0d, required 6", lat);
        end
        step();
        n_checks++;
        if (bus.fault_count !== 8'd0 || bus.fault_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_status: got det=%b cnt=%0d, required det=0 cnt=0",
                     bus.fault_detected, bus.fault_count);
        end
    endtask

    task automatic test_fault();
        int lat;
        run_access(3, 1'b0, lat);
        n_checks++;
        if (lat !== 6 || bus.fault_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_report: got lat=%0d irq=%b, required lat=6 irq=1", lat, bus.fault_irq);
        end
        n_checks++;
        if (bus.fault_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_det_timing: got det=%b during report, required 0", bus.fault_detected);
        end
        step();
        bus.nFault_in = 1'b1;
        n_checks++;
        if (bus.fault_detected !== 1'b1 || bus.fault_count !== 8'd1) begin
            n_fail++;
            $display("FAIL fault_status: got det=%b cnt=%0d, required det=1 cnt=1",
                     bus.fault_detected, bus.fault_count);
        end
    endtask

    task automatic test_clear();
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        model_count = 0;
        model_det   = 1'b0;
        n_checks++;
        if (bus.fault_detected !== 1'b0 || bus.fault_count !== 8'd0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL clear: got det=%b cnt=%0d state=%0d, required 0 0 0",
                     bus.fault_detected, bus.fault_count, dbg_state);
        end
    endtask

    task automatic test_nf_outside();
        int base_done;
        int lat;
        base_done = done_seen;
        for (int i = 0; i < 20; i++) begin
            bus.nFault_in = 1'($urandom_range(0, 1));
            step();
        end
        bus.nFault_in = 1'b1;
        repeat (3) step();
        n_checks++;
        if (bus.fault_detected !== 1'b0 || bus.fault_count !== 8'd0 || done_seen !== base_done) begin
            n_fail++;
            $display("FAIL idle_toggle: got det=%b cnt=%0d dones=%0d, required 0 0 %0d",
                     bus.fault_detected, bus.fault_count, done_seen, base_done);
        end
        // Line low only during the access and released at its end: no fault at the sample point.
        exp_q.push_back(1'b0);
        drive_access(3, 1'b0);
        bus.nFault_in = 1'b1;
        wait_sample(lat);
        step();
        n_checks++;
        if (lat !== 6 || bus.fault_count !== 8'd0) begin
            n_fail++;
            $display("FAIL low_during_access: got lat=%0d cnt=%0d, required 6 0", lat, bus.fault_count);
        end
    endtask

    task automatic test_abort();
        int base_done;
        int lat;
        base_done = done_seen;
        drive_access(3, 1'b1);
        repeat (2) step();
        exp_q.push_back(1'b0);
        drive_access(2, 1'b1);
        wait_sample(lat);
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL abort_latency: got %0d, required 6", lat);
        end
        repeat (12) step();
        n_checks++;
        if (done_seen - base_done !== 1) begin
            n_fail++;
            $display("FAIL abort_done_count: got %0d, required 1", done_seen - base_done);
        end
    endtask

    task automatic test_saturate();
        int lat;
        for (int i = 0; i < 255; i++) begin
            run_access(1, 1'b0, lat);
            step();
        end
        n_checks++;
        if (bus.fault_count !== 8'd255 || bus.fault_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL count_255: got det=%b cnt=%0d, required det=1 cnt=255",
                     bus.fault_detected, bus.fault_count);
        end
        run_access(1, 1'b0, lat);
        step();
        n_checks++;
        if (bus.fault_count !== 8'(model_count)) begin
            n_fail++;
            $display("FAIL count_saturate: got %0d, required %0d", bus.fault_count, model_count);
        end
        // clear lands on the same edge as a fault report
        run_access(1, 1'b0, lat);
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        bus.nFault_in   = 1'b1;
        model_count = 1;
        model_det   = 1'b1;
        n_checks++;
        if (bus.fault_count !== 8'd1 || bus.fault_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_with_fault: got det=%b cnt=%0d, required det=1 cnt=1",
                     bus.fault_detected, bus.fault_count);
        end
    endtask

    task automatic test_reset_mid();
        int base_done;
        int lat;
        drive_access(3, 1'b1);
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.sample_done, bus.fault_irq, bus.fault_detected} !== 3'b000 ||
            bus.fault_count !== 8'd0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got done=%b irq=%b det=%b cnt=%0d state=%0d, required all 0",
                     bus.sample_done, bus.fault_irq, bus.fault_detected, bus.fault_count, dbg_state);
        end
        step();
        reset = 1'b0;
        model_count = 0;
        model_det   = 1'b0;
        base_done = done_seen;
        repeat (15) step();
        n_checks++;
        if (done_seen !== base_done) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d dones, required 0", done_seen - base_done);
        end
        run_access(2, 1'b1, lat);
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got latency %0d, required 6", lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   len;
        logic nf;
        for (int i = 0; i < 10; i++) begin
            len = $urandom_range(1, 5);
            nf  = 1'($urandom_range(0, 1));
            run_access(len, nf, lat);
            step();
            n_checks++;
            if (lat !== 6 || bus.fault_count !== 8'(model_count) || bus.fault_detected !== model_det) begin
                n_fail++;
                $display("FAIL b2b_%0d: got lat=%0d cnt=%0d det=%b, required 6 %0d %b",
                         i, lat, bus.fault_count, bus.fault_detected, model_count, model_det);
            end
        end
        bus.nFault_in = 1'b1;
    endtask

`ifdef NFAULT_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        int lat;
        exp_q.push_back(1'b0);
        drive_access(3, 1'b1);
        repeat (3) step();
        bus.nFault_in = 1'b0;
        step();
        bus.nFault_in = 1'b1;
        wait_sample(lat);
        step();
        n_checks++;
        if (lat < 0 || bus.fault_count !== 8'(model_count)) begin
            n_fail++;
            $display("FAIL glitch_ignored: got lat=%0d cnt=%0d, required done and cnt=%0d",
                     lat, bus.fault_count, model_count);
        end
        run_access(3, 1'b0, lat);
        step();
        bus.nFault_in = 1'b1;
        n_checks++;
        if (lat !== 6 || bus.fault_count !== 8'(model_count) || bus.fault_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL long_low_fault: got lat=%0d cnt=%0d det=%b, required 6 %0d 1",
                     lat, bus.fault_count, bus.fault_detected, model_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_fault();
        test_clear();
        test_nf_outside();
        test_abort();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
`ifdef NFAULT_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        repeat (10) step();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL pending_samples: got %0d unreported, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
